// File: rtl/synth_pkg.sv
// Shared types and tuning constants for the polyphonic synthesiser.
// Default half-periods assume a 12 MHz clock.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam int HALF_PERIOD_W = 16;
  localparam int MAX_VOICES    = 8;

  // Entry 0 is voice 0; entries 4..7 only matter for 8-voice builds.
  localparam logic [MAX_VOICES-1:0][HALF_PERIOD_W-1:0]
    DEFAULT_HALF_PERIODS = {
      16'd4296, 16'd4551, 16'd5107, 16'd5405,
      16'd5731, 16'd7653, 16'd9104, 16'd11472
    };

endpackage

// File: rtl/synth_voice.sv
// One voice: button synchroniser, ADSR-style envelope FSM
// and square-wave tone generator gated by the envelope.
module synth_voice
  import synth_pkg::*;
#(
  parameter int PWM_BITS        = 8,
  parameter int ENV_STEP_CYCLES = 256,
  parameter logic [HALF_PERIOD_W-1:0] HALF_PERIOD = 16'd11472
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button,
  output logic [PWM_BITS-1:0] sample,
  output logic                active
);

  localparam int STEP_W =
    (ENV_STEP_CYCLES > 1) ? $clog2(ENV_STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(ENV_STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] ENV_MAX = '1;
  localparam logic [HALF_PERIOD_W-1:0] TONE_LAST =
    HALF_PERIOD - 1'b1;

  logic [1:0]               sync_q, sync_d;
  env_state_t               state_q, state_d;
  logic [PWM_BITS-1:0]      env_q, env_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic [HALF_PERIOD_W-1:0] tone_q, tone_d;
  logic                     phase_q, phase_d;
  logic                     btn;
  logic                     step_tick;

  assign btn       = sync_q[1];
  assign step_tick = (step_q == STEP_LAST);

  always_comb begin
    sync_d  = {sync_q[0], button};
    state_d = state_q;
    env_d   = env_q;
    unique case (state_q)
      IDLE: begin
        if (btn) state_d = ATTACK;
      end
      ATTACK: begin
        if (!btn)                state_d = RELEASE;
        else if (env_q == ENV_MAX) state_d = SUSTAIN;
        else if (step_tick)      env_d = env_q + 1'b1;
      end
      SUSTAIN: begin
        if (!btn) state_d = RELEASE;
      end
      RELEASE: begin
        // Re-press resumes the attack from the current level.
        if (btn)                 state_d = ATTACK;
        else if (env_q == '0)    state_d = IDLE;
        else if (step_tick)      env_d = env_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)
      step_d = '0;
    else if (state_q == ATTACK || state_q == RELEASE)
      step_d = step_tick ? '0 : step_q + 1'b1;
    else
      step_d = '0;

    tone_d  = tone_q;
    phase_d = phase_q;
    if (state_q == IDLE) begin
      tone_d  = '0;
      phase_d = 1'b0;
    end else if (tone_q == TONE_LAST) begin
      tone_d  = '0;
      phase_d = ~phase_q;
    end else begin
      tone_d  = tone_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      env_q   <= '0;
      step_q  <= '0;
      tone_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      env_q   <= env_d;
      step_q  <= step_d;
      tone_q  <= tone_d;
      phase_q <= phase_d;
    end
  end

  assign sample = phase_q ? env_q : '0;
  assign active = (state_q != IDLE);

endmodule

// File: rtl/poly_synth.sv
// Polyphonic button synth: per-voice envelopes mixed
// into a single PWM audio stream with amplifier control.
module poly_synth
  import synth_pkg::*;
#(
  parameter int   NUM_VOICES      = 4,
  parameter int   PWM_BITS        = 8,
  parameter int   ENV_STEP_CYCLES = 256,
  parameter logic [MAX_VOICES-1:0][HALF_PERIOD_W-1:0]
                  HALF_PERIODS    = DEFAULT_HALF_PERIODS,
  parameter logic GAIN            = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_VOICES-1:0] buttons,
  output logic                  pwm_out,
  output logic                  shutdown_b,
  output logic                  gain
);

  localparam int MIX_SH = $clog2(NUM_VOICES);
  localparam int SUM_W  = PWM_BITS + MIX_SH;
  localparam logic [PWM_BITS-1:0] PWM_LAST = '1;

  logic [NUM_VOICES-1:0][PWM_BITS-1:0] voice_sample;
  logic [NUM_VOICES-1:0]               voice_active;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    synth_voice #(
      .PWM_BITS       (PWM_BITS),
      .ENV_STEP_CYCLES(ENV_STEP_CYCLES),
      .HALF_PERIOD    (HALF_PERIODS[i])
    ) u_voice (
      .clk   (clk),
      .rst   (rst),
      .button(buttons[i]),
      .sample(voice_sample[i]),
      .active(voice_active[i])
    );
  end

  logic [SUM_W-1:0]    sum;
  logic [PWM_BITS-1:0] mix;

  // Sum is wide enough for all voices at full scale.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      sum = sum + SUM_W'(voice_sample[i]);
  end

  assign mix = PWM_BITS'(sum >> MIX_SH);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] sample_reg_q, sample_reg_d;
  logic                pwm_q, pwm_d;
  logic                shut_q, shut_d;

  always_comb begin
    pwm_cnt_d    = pwm_cnt_q + 1'b1;
    sample_reg_d = (pwm_cnt_q == PWM_LAST) ? mix : sample_reg_q;
    pwm_d        = (pwm_cnt_q < sample_reg_q);
    shut_d       = |voice_active;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q    <= '0;
      sample_reg_q <= '0;
      pwm_q        <= 1'b0;
      shut_q       <= 1'b0;
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      sample_reg_q <= sample_reg_d;
      pwm_q        <= pwm_d;
      shut_q       <= shut_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign shutdown_b = shut_q;
  assign gain       = GAIN;

endmodule

// File: tb/tb_poly_synth.sv
// Self-checking bench for poly_synth with two voices,
// 4-bit samples and one-clock envelope steps.
module tb_poly_synth;
  import synth_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] buttons = 2'b00;
  logic       pwm_out, shutdown_b, gain;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int env_sb[$];
  int frame_sb[$];

  poly_synth #(
    .NUM_VOICES     (2),
    .PWM_BITS       (4),
    .ENV_STEP_CYCLES(1),
    .HALF_PERIODS   ({16'd0, 16'd0, 16'd0, 16'd0,
                      16'd0, 16'd0, 16'd6, 16'd4}),
    .GAIN           (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .buttons   (buttons),
    .pwm_out   (pwm_out),
    .shutdown_b(shutdown_b),
    .gain      (gain)
  );

  always #5 clk = ~clk;

  // Edges since reset release; pwm_cnt should equal cyc mod 16.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  logic [3:0] env0, env1, mix;
  logic       phase0, phase1;
  env_state_t state0, state1;

  assign env0   = dut.g_voice[0].u_voice.env_q;
  assign env1   = dut.g_voice[1].u_voice.env_q;
  assign phase0 = dut.g_voice[0].u_voice.phase_q;
  assign phase1 = dut.g_voice[1].u_voice.phase_q;
  assign state0 = dut.g_voice[0].u_voice.state_q;
  assign state1 = dut.g_voice[1].u_voice.state_q;
  assign mix    = dut.mix;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    buttons = 2'b11;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({pwm_out, shutdown_b, gain} !== 3'b001) begin
        errors++;
        $display("FAIL reset_hold pwm/shdn/gain=%b want 001",
                 {pwm_out, shutdown_b, gain});
      end
    end
    buttons = 2'b00;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if ({pwm_out, shutdown_b, gain} !== 3'b001) begin
        errors++;
        $display("FAIL reset_idle t=%0d got %b want 001",
                 i, {pwm_out, shutdown_b, gain});
      end
    end
  endtask

  task automatic test_single_voice();
    int prev, t15, run, prev_mix, cnt;
    bit run_valid;
    for (int i = 0; i < 8 && (cyc % 8) != 0; i++) tick();
    buttons = 2'b01;
    for (int v = 1; v <= 15; v++) env_sb.push_back(v);
    prev = 0;
    t15 = -1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 3 || t == 4) begin
        checks++;
        if (shutdown_b !== (t == 4)) begin
          errors++;
          $display("FAIL single_shdn t=%0d got %b want %b",
                   t, shutdown_b, (t == 4));
        end
      end
      if (int'(env0) != prev) begin
        checks++;
        if (env_sb.size() == 0 || int'(env0) != env_sb[0]) begin
          errors++;
          $display("FAIL single_env got %0d want %0d",
                   env0, env_sb.size() ? env_sb[0] : -1);
        end
        if (env_sb.size()) void'(env_sb.pop_front());
        prev = int'(env0);
        if (env0 == 4'd15 && t15 < 0) t15 = t;
      end
    end
    checks++;
    if (t15 != 18 || env_sb.size() != 0 || state0 !== SUSTAIN) begin
      errors++;
      $display("FAIL single_attack t15=%0d left=%0d st=%0d want 18 0 %0d",
               t15, env_sb.size(), state0, SUSTAIN);
    end
    env_sb.delete();
    run = 0;
    run_valid = 0;
    prev_mix = int'(mix);
    for (int t = 0; t < 32; t++) begin
      tick();
      checks++;
      if (mix !== 4'd0 && mix !== 4'd7) begin
        errors++;
        $display("FAIL single_mix_val got %0d want 0 or 7", mix);
      end
      run++;
      if (int'(mix) != prev_mix) begin
        if (run_valid) begin
          checks++;
          if (run != 4) begin
            errors++;
            $display("FAIL single_mix_run got %0d want 4", run);
          end
        end
        run_valid = 1;
        run = 0;
        prev_mix = int'(mix);
      end
    end
    for (int i = 0; i < 16 && (cyc % 16) != 0; i++) tick();
    for (int f = 0; f < 3; f++) begin
      frame_sb.push_back(7);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
        tick();
        if (pwm_out === 1'b1) cnt++;
      end
      checks++;
      if (cnt != frame_sb[0]) begin
        errors++;
        $display("FAIL single_pwm_duty got %0d want %0d",
                 cnt, frame_sb[0]);
      end
      void'(frame_sb.pop_front());
    end
  endtask

  task automatic test_release();
    int prev, t0;
    buttons = 2'b00;
    for (int v = 14; v >= 0; v--) env_sb.push_back(v);
    prev = 15;
    t0 = -1;
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (int'(env0) != prev) begin
        checks++;
        if (env_sb.size() == 0 || int'(env0) != env_sb[0]) begin
          errors++;
          $display("FAIL release_env got %0d want %0d",
                   env0, env_sb.size() ? env_sb[0] : -1);
        end
        if (env_sb.size()) void'(env_sb.pop_front());
        prev = int'(env0);
        if (env0 == 4'd0 && t0 < 0) t0 = t;
      end
      if (t == 19) begin
        checks++;
        if (state0 !== IDLE || shutdown_b !== 1'b1) begin
          errors++;
          $display("FAIL release_idle st=%0d shdn=%b want %0d 1",
                   state0, shutdown_b, IDLE);
        end
      end
      if (t == 20) begin
        checks++;
        if (shutdown_b !== 1'b0) begin
          errors++;
          $display("FAIL release_shdn got %b want 0", shutdown_b);
        end
      end
    end
    checks++;
    if (t0 != 18 || env_sb.size() != 0) begin
      errors++;
      $display("FAIL release_time t0=%0d left=%0d want 18 0",
               t0, env_sb.size());
    end
    env_sb.delete();
    repeat (32) tick();
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if (pwm_out !== 1'b0 || mix !== 4'd0) begin
        errors++;
        $display("FAIL release_quiet pwm=%b mix=%0d want 0 0",
                 pwm_out, mix);
      end
    end
  endtask

  task automatic test_chord();
    int n, exp_mix, seen15;
    buttons = 2'b11;
    n = 0;
    while (!(state0 == SUSTAIN && state1 == SUSTAIN) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL chord_sustain timeout st0=%0d st1=%0d", state0, state1);
      return;
    end
    seen15 = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      exp_mix = ((phase0 ? 15 : 0) + (phase1 ? 15 : 0)) >> 1;
      if (mix == 4'd15) seen15++;
      checks++;
      if (int'(mix) != exp_mix) begin
        errors++;
        $display("FAIL chord_mix got %0d want %0d (ph %b%b)",
                 mix, exp_mix, phase1, phase0);
      end
    end
    checks++;
    if (seen15 == 0) begin
      errors++;
      $display("FAIL chord_peak got %0d cycles at 15 want >0", seen15);
    end
  endtask

  task automatic test_retrigger();
    int n, prev;
    bit zero_seen;
    buttons = 2'b10;
    n = 0;
    while (!(state0 == RELEASE && env0 == 4'd7) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL retrig_wait timeout st0=%0d env0=%0d", state0, env0);
      return;
    end
    buttons = 2'b11;
    env_sb.push_back(6);
    env_sb.push_back(5);
    for (int v = 6; v <= 15; v++) env_sb.push_back(v);
    prev = 7;
    zero_seen = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (env0 == 4'd0) zero_seen = 1;
      if (t == 3) begin
        checks++;
        if (state0 !== ATTACK || env0 !== 4'd5) begin
          errors++;
          $display("FAIL retrig_attack st=%0d env=%0d want %0d 5",
                   state0, env0, ATTACK);
        end
      end
      if (int'(env0) != prev) begin
        checks++;
        if (env_sb.size() == 0 || int'(env0) != env_sb[0]) begin
          errors++;
          $display("FAIL retrig_env got %0d want %0d",
                   env0, env_sb.size() ? env_sb[0] : -1);
        end
        if (env_sb.size()) void'(env_sb.pop_front());
        prev = int'(env0);
      end
    end
    checks++;
    if (zero_seen || env_sb.size() != 0 || state0 !== SUSTAIN) begin
      errors++;
      $display("FAIL retrig_end zero=%0b left=%0d st=%0d want 0 0 %0d",
               zero_seen, env_sb.size(), state0, SUSTAIN);
    end
    env_sb.delete();
  endtask

  task automatic test_midnote_reset();
    int n;
    n = 0;
    while (pwm_out !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL midreset_pwm timeout pwm=%b want 1", pwm_out);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({pwm_out, shutdown_b, gain} !== 3'b001 ||
        env0 !== 4'd0 || env1 !== 4'd0 ||
        state0 !== IDLE || state1 !== IDLE || mix !== 4'd0) begin
      errors++;
      $display("FAIL midreset_async out=%b env=%0d/%0d mix=%0d want 001 0/0 0",
               {pwm_out, shutdown_b, gain}, env0, env1, mix);
    end
    tick();
    buttons = 2'b10;
    rst = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (t >= 3) begin
        checks++;
        if (shutdown_b !== (t == 4)) begin
          errors++;
          $display("FAIL midreset_restart t=%0d shdn=%b want %b",
                   t, shutdown_b, (t == 4));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_single_voice();
    test_release();
    test_chord();
    test_retrigger();
    test_midnote_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_synth.md
POLY_SYNTH -- requirements
Module: poly_synth

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of button/voice channels (power of two, 1..8).
REQ-002 SHALL have parameter PWM_BITS, default 8, sample and PWM counter width.
REQ-003 SHALL have parameter ENV_STEP_CYCLES, default 256, clocks per envelope step (>=1).
REQ-004 SHALL have parameter HALF_PERIODS, default synth_pkg::DEFAULT_HALF_PERIODS, per-voice tone half-period in clocks (16-bit each, >=2).
REQ-005 SHALL have parameter GAIN, default 1'b0, value driven on gain.
REQ-006 SHALL have port clk  input  1  system clock, one clock domain.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port buttons  input  NUM_VOICES  raw asynchronous key inputs, bit i gates voice i.
REQ-009 SHALL have port pwm_out  output  1  PWM audio.
REQ-010 SHALL have port shutdown_b  output  1  amplifier enable, high while any voice is sounding.
REQ-011 SHALL have port gain  output  1  amplifier gain select.

Function
REQ-012 SHALL pass each buttons bit through a two-flop synchroniser; a voice reacts on the third rising edge after a button change.
REQ-013 SHALL give each voice an envelope FSM with states IDLE, ATTACK, SUSTAIN, RELEASE and a PWM_BITS envelope level env.
REQ-014 SHALL transition IDLE->ATTACK on synced button high; ATTACK->SUSTAIN when env reaches all-ones; ATTACK/SUSTAIN->RELEASE on synced button low; RELEASE->IDLE when env reaches 0; RELEASE->ATTACK on synced button high, resuming from current env (no jump to 0).
REQ-015 SHALL step env +1 (ATTACK) or -1 (RELEASE) once per ENV_STEP_CYCLES clocks via a per-voice step counter cleared on every state change; env saturates, never wraps.
REQ-016 SHALL run a per-voice tone counter 0..HALF_PERIODS[i]-1 that wraps and toggles phase; in IDLE counter and phase are held at 0.
REQ-017 SHALL form voice sample = phase ? env : 0.
REQ-018 SHALL mix as (sum of all voice samples) >> log2(NUM_VOICES), sum width PWM_BITS+log2(NUM_VOICES), no overflow possible.
REQ-019 SHALL run a free-running PWM_BITS counter pwm_cnt; load sample_reg from the mix when pwm_cnt is all-ones; register pwm_out = (pwm_cnt < sample_reg).
REQ-020 SHALL register shutdown_b = 1 when any voice state is not IDLE, one clock after the state change.
REQ-021 SHALL drive gain = GAIN continuously.
REQ-022 SHALL treat simultaneous press of several buttons independently per voice; no voice stealing.

Reset
REQ-023 SHALL, while rst high, force immediately: all FSMs IDLE, env 0, tone counters/phase 0, step counters 0, synchronisers 0, pwm_cnt 0, sample_reg 0, pwm_out 0, shutdown_b 0; gain stays GAIN.
REQ-024 SHALL restart from that state on the first edge after rst falls, including when asserted mid-note.

Structure
REQ-025 SHALL place env_state_t enum, DEFAULT_HALF_PERIODS (12 MHz: 11472, 9104, 7653, 5731) and HALF_PERIOD_W=16 in package synth_pkg.
REQ-026 SHALL implement per-voice synchroniser, FSM, envelope and tone counter in sub-module synth_voice, instantiated NUM_VOICES times by generate.

Verification (NUM_VOICES=2, PWM_BITS=4, ENV_STEP_CYCLES=1, HALF_PERIODS={4,6}, GAIN=1)
REQ-027 SHALL check reset: rst high with buttons=2'b11 -> pwm_out=0, shutdown_b=0, gain=1 throughout; after release with buttons=0 outputs stay 0 for 100 clocks.
REQ-028 SHALL check single voice: buttons=2'b01 -> shutdown_b high 4 clocks later, env0 reaches 15 after 15 steps, mix alternates 0/7 every 4 clocks, pwm_out high 7 of 16 cycles in loaded frames.
REQ-029 SHALL check release: buttons=0 after SUSTAIN -> env0 falls 15->0 over 15 clocks, FSM IDLE, shutdown_b low one clock later, pwm_out 0 thereafter.
REQ-030 SHALL check chord: buttons=2'b11 in SUSTAIN -> mix takes only values 0, 7, 15; 15 exactly when both phases high.
REQ-031 SHALL check retrigger: button 0 re-pressed at env=5 in RELEASE -> ATTACK resumes 6,7,...,15, never 0.
REQ-032 SHALL check mid-note reset: rst pulse during chord -> all outputs 0 asynchronously, before the next clock edge.
